// File: rtl/exmem_pkg.sv
// Shared types and helpers for the EX->MEM pipeline register.
// The optional skid buffer is enabled with the EXMEM_SKID_EN macro.
package exmem_pkg;

  typedef struct packed {
    logic wb;
    logic regwrite;
    logic mread;
    logic mwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  // Widest stall counter the saturate helper supports.
  localparam int unsigned SAT_MAX_W = 32;

  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] top;
    top = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (value >= top) ? value : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/exmem_entry_reg.sv
// One EX->MEM entry: valid flag, controls and payload with load/clear.
// Clear wins over load and drops the controls while keeping the payload.
module exmem_entry_reg
  import exmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  ctrl_t             d_ctrl,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [RD_W-1:0]   d_rd,
  output logic              valid,
  output ctrl_t             ctrl,
  output logic [DATA_W-1:0] alu,
  output logic [DATA_W-1:0] wdata,
  output logic [RD_W-1:0]   rd
);

  // NOTE: payload flops are reset as well so every output reads 0 out of reset;
  // non-blocking assignments keep all fields updating from the same pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= CTRL_NONE;
      alu   <= '0;
      wdata <= '0;
      rd    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_NONE;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      alu   <= d_alu;
      wdata <= d_wdata;
      rd    <= d_rd;
    end
  end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready, flush, forwarding tap and stall counter.
// Defining EXMEM_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module exmem_pipe_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RD_W     = 5,
  parameter int STALL_CW = 16
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wb,
  input  logic                in_regwrite,
  input  logic                in_mread,
  input  logic                in_mwrite,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [RD_W-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_wb,
  output logic                out_regwrite,
  output logic                out_mread,
  output logic                out_mwrite,
  output logic [DATA_W-1:0]   out_alu,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [RD_W-1:0]     out_rd,
  output logic                fwd_valid,
  output logic [STALL_CW-1:0] stall_cnt
);

  ctrl_t             in_ctrl, main_ctrl, main_d_ctrl;
  logic              main_valid, main_load, main_clear;
  logic [DATA_W-1:0] main_d_alu, main_d_wdata;
  logic [RD_W-1:0]   main_d_rd;
  logic              accept, xfer;
  state_e            state;

  assign in_ctrl = '{wb: in_wb, regwrite: in_regwrite, mread: in_mread, mwrite: in_mwrite};
  assign accept  = in_valid & in_ready;
  assign xfer    = main_valid & out_ready;

`ifdef EXMEM_SKID_EN
  logic              skid_valid, skid_load, skid_clear;
  ctrl_t             skid_ctrl;
  logic [DATA_W-1:0] skid_alu, skid_wdata;
  logic [RD_W-1:0]   skid_rd;

  assign in_ready = !skid_valid;
  assign state    = skid_valid ? ST_FULL2 : (main_valid ? ST_FULL : ST_EMPTY);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    main_d_ctrl  = in_ctrl;
    main_d_alu   = in_alu;
    main_d_wdata = in_wdata;
    main_d_rd    = in_rd;
    case (state)
      ST_EMPTY: main_load = accept;
      ST_FULL: begin
        if (xfer) begin
          main_load  = accept;
          main_clear = !accept;
        end else begin
          skid_load = accept;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so only the skid entry can refill main.
        if (xfer) begin
          main_load    = 1'b1;
          skid_clear   = 1'b1;
          main_d_ctrl  = skid_ctrl;
          main_d_alu   = skid_alu;
          main_d_wdata = skid_wdata;
          main_d_rd    = skid_rd;
        end
      end
      default: ;
    endcase
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  exmem_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_ctrl (in_ctrl),
    .d_alu  (in_alu),
    .d_wdata(in_wdata),
    .d_rd   (in_rd),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .alu    (skid_alu),
    .wdata  (skid_wdata),
    .rd     (skid_rd)
  );
`else
  assign in_ready = !main_valid | out_ready;
  assign state    = main_valid ? ST_FULL : ST_EMPTY;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    main_d_ctrl  = in_ctrl;
    main_d_alu   = in_alu;
    main_d_wdata = in_wdata;
    main_d_rd    = in_rd;
    case (state)
      ST_EMPTY: main_load = accept;
      ST_FULL: begin
        if (xfer) begin
          main_load  = accept;
          main_clear = !accept;
        end
      end
      default: ;
    endcase
    if (flush) main_clear = 1'b1;
  end
`endif

  exmem_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_alu  (main_d_alu),
    .d_wdata(main_d_wdata),
    .d_rd   (main_d_rd),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .alu    (out_alu),
    .wdata  (out_wdata),
    .rd     (out_rd)
  );

  assign out_valid    = main_valid;
  assign out_wb       = main_ctrl.wb;
  assign out_regwrite = main_ctrl.regwrite;
  assign out_mread    = main_ctrl.mread;
  assign out_mwrite   = main_ctrl.mwrite;
  assign fwd_valid    = main_valid & main_ctrl.regwrite & (out_rd != '0);

  // Flush leaves the counter alone; only reset clears it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready) begin
      stall_cnt <= STALL_CW'(sat_inc(SAT_MAX_W'(stall_cnt), STALL_CW));
    end
  end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed self-checking bench for exmem_pipe_stage (STALL_CW=4 to reach saturation).
// Builds with or without EXMEM_SKID_EN; the stall section adapts its expectations.
module tb_exmem_pipe_stage;

  localparam int DATA_W   = 32;
  localparam int RD_W     = 5;
  localparam int STALL_CW = 4;

  logic                clock = 1'b0;
  logic                rst_n = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_wb = 1'b0, in_regwrite = 1'b0, in_mread = 1'b0, in_mwrite = 1'b0;
  logic [DATA_W-1:0]   in_alu = '0, in_wdata = '0;
  logic [RD_W-1:0]     in_rd = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                out_wb, out_regwrite, out_mread, out_mwrite;
  logic [DATA_W-1:0]   out_alu, out_wdata;
  logic [RD_W-1:0]     out_rd;
  logic                fwd_valid;
  logic [STALL_CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  exmem_pipe_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .STALL_CW(STALL_CW)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wb       (in_wb),
    .in_regwrite (in_regwrite),
    .in_mread    (in_mread),
    .in_mwrite   (in_mwrite),
    .in_alu      (in_alu),
    .in_wdata    (in_wdata),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wb      (out_wb),
    .out_regwrite(out_regwrite),
    .out_mread   (out_mread),
    .out_mwrite  (out_mwrite),
    .out_alu     (out_alu),
    .out_wdata   (out_wdata),
    .out_rd      (out_rd),
    .fwd_valid   (fwd_valid),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic v, input logic wb, input logic rw, input logic mr,
                         input logic mw, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd);
    in_valid    = v;
    in_wb       = wb;
    in_regwrite = rw;
    in_mread    = mr;
    in_mwrite   = mw;
    in_alu      = alu;
    in_wdata    = wd;
    in_rd       = rd;
  endtask

  initial begin
    // Reset with random inputs and a running clock.
    #2 rst_n = 1'b0;
    present(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom));
    out_ready = 1'($urandom);
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ctrl", {28'd0, out_wb, out_regwrite, out_mread, out_mwrite}, 32'd0);
    check("rst_out_alu", out_alu, 32'd0);
    check("rst_out_wdata", out_wdata, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_fwd", 32'(fwd_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // First beat after release: one-cycle latency.
    rst_n = 1'b1;
    out_ready = 1'b1;
    present(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h55, 5'd2);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_alu", out_alu, 32'h1234);
    check("first_wb", 32'(out_wb), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bubble_valid", 32'(out_valid), 32'd0);
    check("bubble_wb", 32'(out_wb), 32'd0);
    check("bubble_alu_hold", out_alu, 32'h1234);

    // Streaming: 8 back-to-back beats.
    for (int i = 0; i < 8; i++) begin
      present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i + 1));
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_alu", out_alu, 32'h100 + 32'(i));
      check("stream_wdata", out_wdata, 32'h200 + 32'(i));
      check("stream_rd", 32'(out_rd), 32'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", 32'(out_valid), 32'd0);

    // Stall: beat A held for 3 cycles, beat B waiting.
    out_ready = 1'b0;
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA, 32'hAA, 5'd3);
    tick();
    check("stall_load_valid", 32'(out_valid), 32'd1);
    check("stall_load_cnt", 32'(stall_cnt), 32'd0);
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB, 32'hBB, 5'd4);
    #1;
`ifdef EXMEM_SKID_EN
    check("stall_in_ready_skid", 32'(in_ready), 32'd1);
`else
    check("stall_in_ready_base", 32'(in_ready), 32'd0);
`endif
    tick();
`ifdef EXMEM_SKID_EN
    in_valid = 1'b0;
`endif
    check("stall_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("stall_valid_hold", 32'(out_valid), 32'd1);
    check("stall_alu_hold", out_alu, 32'hA);
    check("stall_rd_hold", 32'(out_rd), 32'd3);
    check("stall_cnt_3", 32'(stall_cnt), 32'd3);
    check("stall_in_ready_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
`ifdef EXMEM_SKID_EN
    check("release_in_ready_skid", 32'(in_ready), 32'd0);
`else
    check("release_in_ready_base", 32'(in_ready), 32'd1);
`endif
    tick();
    check("release_alu_b", out_alu, 32'hB);
    check("release_rd_b", 32'(out_rd), 32'd4);
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_cnt", 32'(stall_cnt), 32'd3);
    in_valid = 1'b0;
    tick();
    check("release_drain", 32'(out_valid), 32'd0);
    check("release_drain_rw", 32'(out_regwrite), 32'd0);

    // Flush while a beat is presented: beat discarded.
    flush = 1'b1;
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 5'd9);
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_regwrite", 32'(out_regwrite), 32'd0);
    check("flush_fwd", 32'(fwd_valid), 32'd0);
    check("flush_alu_hold", out_alu, 32'hB);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_never_seen", 32'(out_valid), 32'd0);

    // Flush of a held, stalled entry: counter keeps its value.
    out_ready = 1'b0;
    present(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC, 32'hCC, 5'd5);
    tick();
    check("flush_held_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_held_empty", 32'(out_valid), 32'd0);
    check("flush_held_ctrl", {28'd0, out_wb, out_regwrite, out_mread, out_mwrite}, 32'd0);
    flush = 1'b0;
    tick();
    check("flush_held_cnt", 32'(stall_cnt), 32'd4);

    // Forwarding tap.
    out_ready = 1'b1;
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h70, 32'h0, 5'd0);
    tick();
    check("fwd_rd0_valid", 32'(out_valid), 32'd1);
    check("fwd_rd0", 32'(fwd_valid), 32'd0);
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h71, 32'h0, 5'd7);
    tick();
    check("fwd_rd7", 32'(fwd_valid), 32'd1);
    present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h72, 32'h0, 5'd7);
    tick();
    check("fwd_no_rw", 32'(fwd_valid), 32'd0);
    check("fwd_mread", 32'(out_mread), 32'd1);
    in_valid = 1'b0;
    tick();
    check("fwd_bubble", 32'(fwd_valid), 32'd0);

    // Saturation: counter starts at 4 and caps at 15.
    out_ready = 1'b0;
    present(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h98, 5'd6);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5)  check("sat_cnt_9", 32'(stall_cnt), 32'd9);
      if (k == 11) check("sat_cnt_15", 32'(stall_cnt), 32'd15);
      if (k == 20) check("sat_cnt_hold", 32'(stall_cnt), 32'd15);
    end
    check("sat_alu_hold", out_alu, 32'h99);

    // Async reset mid-transfer drops the beat at once.
    out_ready = 1'b1;
    present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h66, 5'd8);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_alu", out_alu, 32'd0);
    check("async_cnt", 32'(stall_cnt), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
